fsmc_bridge_mux: RTL and testbench

FSMC_BRIDGE_MUX -- requirements
Module: fsmc_bridge_mux

---
 rtl/fsmc_bridge_mux.sv | 221 ++++++++++++++++++++++
 tb/tb_fsmc_bridge_mux.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsmc_bridge_mux.sv
`default_nettype none
// ============================================================================
// Module   : fsmc_bridge_mux
// Purpose  : Bridges an asynchronous multiplexed-AD FSMC host port onto
//            NUM_SLAVES one-hot strobed register slaves, with burst addressing.
// Revision : 1.0 - initial release
// ============================================================================
module fsmc_bridge_mux #(
    parameter int AD_WIDTH       = 18,
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_SLAVES     = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int RD_HOLD_CYCLES = 2
) (
    input  logic                             clk,
    input  logic                             reset_n,
    inout  wire  [AD_WIDTH-1:0]              AD,
    input  logic                             NADV,
    input  logic                             NWE,
    input  logic                             NOE,
    output logic [DATA_WIDTH-1:0]            addr,
    output logic [DATA_WIDTH-1:0]            wdata,
    output logic [NUM_SLAVES-1:0]            wr_stb,
    output logic [NUM_SLAVES-1:0]            rd_stb,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] rd_data,
    output logic                             err,
    input  logic                             err_clr
);

    localparam int c_SEL_WIDTH = AD_WIDTH - DATA_WIDTH;
    localparam int c_CNT_WIDTH = (RD_HOLD_CYCLES < 2) ? 1 : $clog2(RD_HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WR   = 3'd2,
        S_RD   = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    // Host strobe bit order: [2]=NADV, [1]=NWE, [0]=NOE
    logic [2:0] w_host_raw;
    logic [2:0] w_host_sync;
    logic [2:0] r_host_prev;
    logic [2:0] w_fall;
    logic [2:0] w_rise;

    state_t                  r_state;
    logic                    r_open;
    logic                    r_wr_done;
    logic                    r_drive;
    logic                    r_err;
    logic [c_SEL_WIDTH-1:0]  r_sel;
    logic [DATA_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_dout;
    logic [NUM_SLAVES-1:0]   r_wr_stb;
    logic [NUM_SLAVES-1:0]   r_rd_stb;
    logic [c_CNT_WIDTH-1:0]  r_hold_cnt;

    logic [NUM_SLAVES-1:0]   w_onehot;
    logic                    w_sel_ok;
    logic [DATA_WIDTH-1:0]   w_rd_mux;
    logic                    w_err_set;

    assign w_host_raw = {NADV, NWE, NOE};

    for (genvar g = 0; g < 3; g++) begin : g_sync
        logic [SYNC_STAGES-1:0] r_chain;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_chain <= '1;
            end else begin
                r_chain <= (r_chain << 1) | SYNC_STAGES'(w_host_raw[g]);
            end
        end

        assign w_host_sync[g] = r_chain[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_host_prev <= '1;
        end else begin
            r_host_prev <= w_host_sync;
        end
    end

    assign w_fall = r_host_prev & ~w_host_sync;
    assign w_rise = ~r_host_prev & w_host_sync;

    // An out-of-range select decodes to all zeros, which suppresses strobes and read data.
    for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_dec
        assign w_onehot[s] = (r_sel == c_SEL_WIDTH'(s));
    end

    assign w_sel_ok = |w_onehot;

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (w_onehot[i]) begin
                w_rd_mux = w_rd_mux | rd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_err_set = 1'b0;
        if (r_state == S_IDLE && r_open && !w_fall[2]) begin
            if (w_fall[1] && w_fall[0]) begin
                w_err_set = 1'b1;
            end else if ((w_fall[1] || w_fall[0]) && !w_sel_ok) begin
                w_err_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_open     <= 1'b0;
            r_wr_done  <= 1'b0;
            r_drive    <= 1'b0;
            r_err      <= 1'b0;
            r_sel      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_dout     <= '0;
            r_wr_stb   <= '0;
            r_rd_stb   <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_wr_stb <= '0;
            r_rd_stb <= '0;

            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end

            // A new address cycle pre-empts everything, including an active read.
            if (w_fall[2]) begin
                r_state   <= S_ADDR;
                r_open    <= 1'b0;
                r_drive   <= 1'b0;
                r_wr_done <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_open && !(w_fall[1] && w_fall[0])) begin
                            if (w_fall[1]) begin
                                r_state <= S_WR;
                            end else if (w_fall[0]) begin
                                r_state  <= S_RD;
                                r_rd_stb <= w_onehot;
                                r_drive  <= 1'b1;
                                r_dout   <= w_rd_mux;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (w_rise[2]) begin
                            r_sel   <= AD[AD_WIDTH-1:DATA_WIDTH];
                            r_addr  <= AD[DATA_WIDTH-1:0];
                            r_open  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                    S_WR: begin
                        if (r_wr_done) begin
                            r_wr_done <= 1'b0;
                            r_addr    <= r_addr + DATA_WIDTH'(1);
                            r_state   <= S_IDLE;
                        end else if (w_rise[1]) begin
                            r_wdata   <= AD[DATA_WIDTH-1:0];
                            r_wr_stb  <= w_onehot;
                            r_wr_done <= 1'b1;
                        end
                    end
                    S_RD: begin
                        r_dout <= w_rd_mux;
                        if (w_rise[0]) begin
                            r_addr <= r_addr + DATA_WIDTH'(1);
                            if (RD_HOLD_CYCLES == 0) begin
                                r_drive <= 1'b0;
                                r_state <= S_IDLE;
                            end else begin
                                r_hold_cnt <= c_CNT_WIDTH'(RD_HOLD_CYCLES);
                                r_state    <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (r_hold_cnt <= c_CNT_WIDTH'(1)) begin
                            r_drive <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_hold_cnt <= r_hold_cnt - c_CNT_WIDTH'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Select bits are never driven; the reset clears r_drive so AD floats immediately.
    assign AD     = r_drive ? {{c_SEL_WIDTH{1'bz}}, r_dout} : {AD_WIDTH{1'bz}};
    assign addr   = r_addr;
    assign wdata  = r_wdata;
    assign wr_stb = r_wr_stb;
    assign rd_stb = r_rd_stb;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fsmc_bridge_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsmc_bridge_mux
// Purpose  : Directed plus random host-bus stimulus for fsmc_bridge_mux with a
//            strobe scoreboard and direct AD/err checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsmc_bridge_mux;

    localparam int AW = 18;
    localparam int DW = 16;
    localparam int NS = 3;
    localparam logic [AW-1:0] REL = '1;

    logic              clk     = 1'b0;
    logic              reset_n = 1'b0;
    logic              nadv    = 1'b1;
    logic              nwe     = 1'b1;
    logic              noe     = 1'b1;
    logic              err_clr = 1'b0;
    logic              host_oe = 1'b0;
    logic [AW-1:0]     host_ad = '0;
    logic [NS*DW-1:0]  rd_data = '0;
    logic [DW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic [NS-1:0]     wr_stb;
    logic [NS-1:0]     rd_stb;
    logic              err;
    tri1  [AW-1:0]     AD;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic          is_wr;
        logic [NS-1:0] stb;
        logic [DW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];

    logic [1:0]    m_sel  = '0;
    logic [DW-1:0] m_addr = '0;
    logic          m_open = 1'b0;
    logic          m_err  = 1'b0;

    assign AD = host_oe ? host_ad : 'z;

    fsmc_bridge_mux #(
        .AD_WIDTH       (AW),
        .DATA_WIDTH     (DW),
        .NUM_SLAVES     (NS),
        .SYNC_STAGES    (2),
        .RD_HOLD_CYCLES (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .AD      (AD),
        .NADV    (nadv),
        .NWE     (nwe),
        .NOE     (noe),
        .addr    (addr),
        .wdata   (wdata),
        .wr_stb  (wr_stb),
        .rd_stb  (rd_stb),
        .rd_data (rd_data),
        .err     (err),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: timeout, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [NS-1:0] oh(input logic [1:0] s);
        logic [NS-1:0] r;
        r = '0;
        if (s < NS) r[s] = 1'b1;
        return r;
    endfunction

    function automatic logic [DW-1:0] slave_data(input logic [1:0] s);
        if (s < NS) return rd_data[s*DW +: DW];
        return '0;
    endfunction

    // Strobe scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && ((wr_stb | rd_stb) !== '0)) begin
            check("stb_onehot", 32'($countones(wr_stb | rd_stb)), 32'd1);
            if (exp_q.size() == 0) begin
                check("stb_unexpected", {26'd0, wr_stb, rd_stb}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("stb_wr", {29'd0, wr_stb}, {29'd0, e.is_wr ? e.stb : 3'b000});
                check("stb_rd", {29'd0, rd_stb}, {29'd0, e.is_wr ? 3'b000 : e.stb});
                check("stb_addr", {16'd0, addr}, {16'd0, e.addr});
                if (e.is_wr) check("stb_wdata", {16'd0, wdata}, {16'd0, e.data});
            end
        end
    end

    task automatic do_addr(input logic [1:0] sel, input logic [DW-1:0] off);
        host_ad = {sel, off};
        host_oe = 1'b1;
        nadv    = 1'b0;
        tick(5);
        nadv = 1'b1;
        tick(5);
        host_oe = 1'b0;
        m_sel   = sel;
        m_addr  = off;
        m_open  = 1'b1;
    endtask

    task automatic do_write(input logic [DW-1:0] d);
        host_ad = {2'b00, d};
        host_oe = 1'b1;
        nwe     = 1'b0;
        if (m_open && m_sel < NS) exp_q.push_back('{1'b1, oh(m_sel), m_addr, d});
        if (m_open && m_sel >= NS) m_err = 1'b1;
        tick(5);
        nwe = 1'b1;
        tick(5);
        host_oe = 1'b0;
        if (m_open) m_addr++;
    endtask

    task automatic do_read(input bit chk_hold);
        logic [DW-1:0] d;
        d = slave_data(m_sel);
        if (m_open && m_sel < NS) exp_q.push_back('{1'b0, oh(m_sel), m_addr, 16'h0000});
        if (m_open && m_sel >= NS) m_err = 1'b1;
        noe = 1'b0;
        tick(5);
        check("rd_ad", 32'(AD), m_open ? 32'({2'b11, d}) : 32'(REL));
        noe = 1'b1;
        if (chk_hold) begin
            tick(4);
            check("hold_ad", 32'(AD), 32'({2'b11, d}));
            tick(1);
            check("release_ad", 32'(AD), 32'(REL));
            tick(5);
        end else begin
            tick(10);
        end
        if (m_open) m_addr++;
    endtask

    task automatic clr_err();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        m_err   = 1'b0;
    endtask

    initial begin
        rd_data = {16'h1234, 16'hA5C3, 16'h0F0F};
        tick(3);
        check("rst_ad", 32'(AD), 32'(REL));
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        check("rst_stb", {26'd0, wr_stb, rd_stb}, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Single write to slave 1
        do_addr(2'd1, 16'h0040);
        do_write(16'hBEEF);
        check("wr_addr_inc", 32'(addr), 32'h0041);
        check("wr_wdata", 32'(wdata), 32'hBEEF);

        // Read from slave 2 with hold-and-release timing
        do_addr(2'd2, 16'h0010);
        do_read(1'b1);
        check("rd_addr_inc", 32'(addr), 32'h0011);

        // Write burst wrapping the offset
        do_addr(2'd0, 16'hFFFF);
        do_write(16'h1111);
        do_write(16'h2222);
        check("wrap_addr", 32'(addr), 32'h0001);

        // Read burst
        do_addr(2'd1, 16'h0100);
        do_read(1'b0);
        do_read(1'b0);
        check("rburst_addr", 32'(addr), 32'h0102);

        // Out-of-range select
        check("err_pre", 32'(err), 32'd0);
        do_addr(2'd3, 16'h0000);
        do_read(1'b1);
        check("err_set_rd", 32'(err), 32'd1);
        clr_err();
        check("err_clr", 32'(err), 32'd0);
        do_write(16'h7777);
        check("err_set_wr", 32'(err), 32'd1);
        clr_err();

        // Simultaneous NWE/NOE: protocol error, no strobe, stays idle
        do_addr(2'd0, 16'h0200);
        nwe = 1'b0;
        noe = 1'b0;
        tick(5);
        check("proto_err", 32'(err), 32'd1);
        check("proto_ad", 32'(AD), 32'(REL));
        nwe = 1'b1;
        noe = 1'b1;
        tick(5);
        clr_err();
        do_write(16'h3333);
        check("proto_addr", 32'(addr), 32'h0201);

        // NADV during a read aborts it and releases AD
        do_addr(2'd2, 16'h0300);
        exp_q.push_back('{1'b0, oh(2'd2), 16'h0300, 16'h0000});
        noe = 1'b0;
        tick(5);
        check("abort_rd_ad", 32'(AD), 32'({2'b11, 16'h1234}));
        nadv = 1'b0;
        tick(3);
        check("abort_release", 32'(AD), 32'(REL));
        host_ad = {2'd1, 16'h0400};
        host_oe = 1'b1;
        noe     = 1'b1;
        tick(3);
        nadv = 1'b1;
        tick(5);
        host_oe = 1'b0;
        m_sel   = 2'd1;
        m_addr  = 16'h0400;
        do_write(16'h4444);

        // Reset during HOLD
        do_addr(2'd2, 16'h0500);
        exp_q.push_back('{1'b0, oh(2'd2), 16'h0500, 16'h0000});
        noe = 1'b0;
        tick(5);
        noe = 1'b1;
        tick(4);
        check("hold_pre_rst", 32'(AD), 32'({2'b11, 16'h1234}));
        reset_n = 1'b0;
        #1;
        check("rst_hold_ad", 32'(AD), 32'(REL));
        check("rst_hold_addr", 32'(addr), 32'd0);
        check("rst_hold_wdata", 32'(wdata), 32'd0);
        check("rst_hold_err", 32'(err), 32'd0);
        tick(2);
        reset_n = 1'b1;
        m_open  = 1'b0;
        m_sel   = '0;
        m_addr  = '0;
        m_err   = 1'b0;
        tick(2);
        do_read(1'b0);
        do_write(16'h5555);
        check("closed_wdata", 32'(wdata), 32'd0);

        // Random mixed bursts
        for (int b = 0; b < 300; b++) begin
            logic [1:0]    sel;
            logic [DW-1:0] off;
            int            len;
            sel = 2'($urandom_range(0, 3));
            off = ($urandom_range(0, 5) == 0) ? 16'hFFFE : 16'($urandom);
            len = $urandom_range(1, 3);
            do_addr(sel, off);
            for (int k = 0; k < len; k++) begin
                for (int s = 0; s < NS; s++) rd_data[s*DW +: DW] = 16'($urandom);
                if ($urandom_range(0, 1) == 1) do_write(16'($urandom));
                else do_read(1'b0);
                check("rand_err", 32'(err), 32'(m_err));
                check("rand_addr", 32'(addr), 32'(m_addr));
            end
            if ($urandom_range(0, 3) == 0) clr_err();
        end

        tick(10);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
